serial_parity_receiver: RTL and testbench

- Bit-serial frame receiver. Deserialises FRAME_LEN data bits plus one trailing parity bit.
- Checks parity with a running XOR accumulator and presents the parallel word with an error flag over a valid/ready handshake.
- Sits upstream of word-level consumers and downstream of any serial bit source; it is the sequential consumer of the XOR-via-mux gate.

---
 rtl/serial_parity_pkg.sv | 7 +
 rtl/serial_parity_receiver_xor.sv | 8 +
 rtl/serial_parity_receiver.sv | 66 ++++++
 tb/tb_serial_parity_receiver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: shared FSM state type and parity/frame defaults for the serial parity receiver.
package serial_parity_pkg;
  typedef enum logic [1:0] {DATA, PAR, OUT} state_e;
  localparam int FRAME_LEN_DEF = 8;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD = 1'b1;
endpackage

// File: rtl/serial_parity_receiver_xor.sv
// xor_gate_using_mux: two-input XOR built as a 2:1 mux selecting b or ~b.
module xor_gate_using_mux (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? ~b_i : b_i;
endmodule

// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver: deserialises LSB-first frames plus a parity bit and checks parity.
module serial_parity_receiver
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter bit ODD = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_err
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 acc_q;
  logic                 acc_d;
  logic [FRAME_LEN-1:0] sh_q;
  logic                 out_valid_q;
  logic [FRAME_LEN-1:0] out_data_q;
  logic                 out_err_q;
  xor_gate_using_mux u_xor (.a_i(acc_q), .b_i(in_bit), .y_o(acc_d));
  assign in_ready  = state_q != OUT;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DATA;
      cnt_q       <= '0;
      acc_q       <= ODD;
      sh_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        DATA: if (in_valid) begin
          // shift right so the first bit received ends up at bit 0
          sh_q  <= {in_bit, sh_q[FRAME_LEN-1:1]};
          acc_q <= acc_d;
          cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= PAR;
        end
        PAR: if (in_valid) begin
          out_err_q   <= acc_d;
          out_data_q  <= sh_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          acc_q       <= ODD;
          state_q     <= DATA;
        end
        default: state_q <= DATA;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_parity_receiver.sv
// tb_serial_parity_receiver: directed frames into even- and odd-parity receivers, scoreboard-checked.
module tb_serial_parity_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [2];
  logic ib [2];
  logic ordy [2];
  logic ir [2];
  logic ov [2];
  logic [7:0] od [2];
  logic oe [2];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_parity_receiver #(.FRAME_LEN(8), .ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_err(oe[0]));
  serial_parity_receiver #(.FRAME_LEN(8), .ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_bit(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_err(oe[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a handshake completes at the next edge, so pop and compare now
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && ov[k] && ordy[k]) begin
        logic [8:0] e;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("unexpected_frame%0d", k), {23'd0, oe[k], od[k]}, 32'h1ff);
        end else begin
          e = k == 0 ? q0.pop_front() : q1.pop_front();
          chk($sformatf("data%0d", k), {24'd0, od[k]}, {24'd0, e[7:0]});
          chk($sformatf("err%0d", k), {31'd0, oe[k]}, {31'd0, e[8]});
        end
      end
    end
  end

  task automatic send_bit(input int k, input logic b, input int gap);
    logic r;
    int n;
    iv[k] = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    iv[k] = 1'b1;
    ib[k] = b;
    n = 0;
    do begin
      r = ir[k];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 40);
    if (!r) chk("in_ready_timeout", 32'd0, 32'd1);
    iv[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic p, input int gap, input logic err);
    if (k == 0) q0.push_back({err, d});
    else q1.push_back({err, d});
    for (int i = 0; i < 8; i++) send_bit(k, d[i], gap);
    send_bit(k, p, gap);
  endtask

  task automatic drain(input int k);
    int n = 0;
    while ((k == 0 ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", (k == 0 ? q0.size() : q1.size()), 0);
    @(posedge clk);
    #1;
    chk("valid_falls", {31'd0, ov[k]}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      ib[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_data", {24'd0, od[0]}, 32'd0);
    chk("rst_err", {31'd0, oe[0]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
    @(posedge clk);
    #1;
    send_frame(0, 8'hA5, 1'b0, 0, 1'b0);
    drain(0);
    send_frame(0, 8'hA5, 1'b1, 0, 1'b1);
    drain(0);
    // backpressure with in_valid held high and ones offered
    ordy[0] = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 0, 1'b0);
    iv[0] = 1'b1;
    ib[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, ov[0]}, 32'd1);
      chk("bp_data", {24'd0, od[0]}, 32'h3C);
      chk("bp_in_ready", {31'd0, ir[0]}, 32'd0);
    end
    @(posedge clk);
    #1 iv[0] = 1'b0;
    ordy[0] = 1'b1;
    drain(0);
    send_frame(0, 8'h01, 1'b1, 0, 1'b0);
    drain(0);
    send_frame(0, 8'hFF, 1'b0, 2, 1'b0);
    drain(0);
    send_frame(0, 8'h80, 1'b1, 0, 1'b0);
    drain(0);
    send_frame(0, 8'h00, 1'b1, 0, 1'b1);
    drain(0);
    // abort 0xAA after five bits
    for (int i = 0; i < 5; i++) send_bit(0, i[0], 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'd0, ov[0]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, ir[0]}, 32'd1);
    @(posedge clk);
    #1;
    send_frame(0, 8'h0F, 1'b0, 0, 1'b0);
    drain(0);
    send_frame(1, 8'h01, 1'b0, 0, 1'b0);
    drain(1);
    send_frame(1, 8'h03, 1'b0, 1, 1'b1);
    drain(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
